controller_multicycle_fsm: RTL
==============================

// Module: controller_multicycle_fsm
// PURPOSE
//  Main sequencer for the multi-cycle RV32I datapath: one shared ALU, one unified memory, IR/old_pc/ALUOut latches.
//  Walks each instruction through FETCH/DECODE/EXECUTE/MEM/WB states and drives all datapath selects and enables.
//  Branch resolution (beq/bne/blt/bge) is done in the BRANCH state. Per-state ALU function comes from alu_op via the existing ALU decoder.
// PARAMETERS
//  MEM_WAIT  0  extra stall cycles added to every memory-access state (FETCH, MEMREAD, MEMWRITE); 0..15
// PORTS
//  clk         in   1  rising-edge clock
//  rst         in   1  synchronous, active-high reset
//  op          in   7  IR[6:0] opcode
//  f3          in   3  IR[14:12]
//  zero        in   1  ALU result == 0 (same cycle)
//  neg         in   1  ALU result sign bit (same cycle, signed compare)
//  pc_write    out  1  load PC from result bus
//  adr_src     out  1  memory address: 0=PC, 1=result bus
//  mem_write   out  1  memory write strobe
//  ir_write    out  1  load IR and old_pc (old_pc<=PC)
//  reg_write   out  1  register-file write of result bus to rd
//  result_src  out  2  00=ALUOut, 01=mem data, 10=ALU result (direct)
//  alu_src_a   out  2  00=PC, 01=old_pc, 10=reg A (rs1), 11=zero
//  alu_src_b   out  2  00=reg B (rs2), 01=imm, 10=const 4
//  alu_op      out  2  00=add, 01=sub, 10=decode by f3/f7
//  imm_src     out  3  000=I,001=S,010=B,011=J,100=U; decoded from op every cycle
//  instr_done  out  1  1-cycle pulse in last cycle of each instruction
//  illegal_op  out  1  1-cycle pulse in DECODE on unknown opcode
// BEHAVIOUR
//  Moore outputs decoded from state (+wait counter, +f3/zero/neg in BRANCH). Unlisted outputs = 0.
//  Reset: state<=FETCH, wait_cnt<=0; while rst=1 every output forced 0. rst mid-instruction aborts it; no partial writes after reset cycle.
//  Wait counter: memory states hold for MEM_WAIT+1 cycles; wait_cnt counts 0..MEM_WAIT, clears on state exit.
//   ir_write/pc_write (FETCH) and mem_write (MEMWRITE) assert ONLY in the final cycle; adr_src/selects held all cycles.
//  States / outputs / next:
//   FETCH:    adr_src=0,a=00,b=10,alu_op=00,result_src=10; last cycle ir_write=1,pc_write=1 -> DECODE
//   DECODE:   a=01,b=01,alu_op=00 (ALUOut<=branch/jal target). Next by op:
//             0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH,
//             1101111->JAL, 1100111->JALR1, 0110111->LUI, other->FETCH with illegal_op=1
//   MEMADR:   a=10,b=01,alu_op=00 -> MEMREAD if op[5]=0 else MEMWRITE
//   MEMREAD:  adr_src=1,result_src=00 -> MEMWB (after wait)
//   MEMWB:    result_src=01,reg_write=1,instr_done=1 -> FETCH
//   MEMWRITE: adr_src=1,result_src=00; last cycle mem_write=1,instr_done=1 -> FETCH
//   EXECR:    a=10,b=00,alu_op=10 -> ALUWB;   EXECI: a=10,b=01,alu_op=10 -> ALUWB
//   LUI:      a=11,b=01,alu_op=00 -> ALUWB
//   ALUWB:    result_src=00,reg_write=1,instr_done=1 -> FETCH
//   BRANCH:   a=10,b=00,alu_op=01,result_src=00,instr_done=1; pc_write=taken -> FETCH
//             taken: f3 000 zero; 001 !zero; 100 neg; 101 !neg; other f3 never taken
//   JAL:      a=01,b=10,alu_op=00,result_src=00,pc_write=1 -> ALUWB (ALUOut<=old_pc+4 link)
//   JALR1:    a=10,b=01,alu_op=00 -> JALR2 (ALUOut<=rs1+imm)
//   JALR2:    same outputs as JAL -> ALUWB
//  Latency @MEM_WAIT=0: R/I/LUI/JAL/SW 4, LW/JALR 5, branch 3 cycles; +MEM_WAIT per memory state.
//  imm_src: S for 0100011, B for 1100011, J for 1101111, U for 0110111, I otherwise.
//  At most one of pc_write/reg_write/mem_write/ir_write... except FETCH (ir_write+pc_write together).
// TESTING
//  rst=1 two cycles, release -> state FETCH, all outputs 0 during rst, ir_write+pc_write in 1st cycle after.
//  op=0110011, MEM_WAIT=0 -> FETCH,DECODE,EXECR,ALUWB; reg_write=1 only in cycle 4; instr_done cycle 4.
//  op=0000011, MEM_WAIT=2 -> FETCH 3 cycles (ir_write only 3rd), MEMREAD 3 cycles, MEMWB reg_write; total 9 cycles.
//  op=1100011: f3=000 zero=1 -> pc_write=1; f3=001 zero=1 -> 0; f3=100 neg=1 -> 1; f3=101 neg=1 -> 0; f3=010 -> 0.
//  op=1100111 -> JALR1,JALR2(pc_write,result_src=00),ALUWB(reg_write); op=1111111 -> illegal_op pulse, back to FETCH, no writes.
//  rst asserted in MEMWRITE wait cycle (MEM_WAIT=1) -> mem_write never pulses; next state FETCH.

Source files
------------

// File: rtl/controller_multicycle_fsm_if.sv
// Control/status bundle between the multi-cycle sequencer and the RV32I datapath.
// The master is the sequencer; the slave is the datapath.
interface controller_multicycle_fsm_if;
   logic [6:0] op;
   logic [2:0] f3;
   logic       zero;
   logic       neg;
   logic       pc_write;
   logic       adr_src;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [2:0] imm_src;
   logic       instr_done;
   logic       illegal_op;

   modport master (
      input  op, f3, zero, neg,
      output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
             alu_src_a, alu_src_b, alu_op, imm_src, instr_done, illegal_op
   );

   modport slave (
      output op, f3, zero, neg,
      input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
             alu_src_a, alu_src_b, alu_op, imm_src, instr_done, illegal_op
   );
endinterface

// File: rtl/controller_multicycle_fsm.sv
// Main sequencer for the multi-cycle RV32I datapath: walks each instruction through
// fetch/decode/execute/memory/writeback and drives every datapath select and enable.
module controller_multicycle_fsm #(
   parameter int unsigned MEM_WAIT = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   controller_multicycle_fsm_if.master    bus
);
   localparam int unsigned CW = 4;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
      S_EXECI, S_LUI, S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] wait_cnt, wait_nxt;
   logic          mem_state;
   logic          mem_last;
   logic          taken;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   // Next state and Moore outputs; memory states hold until the wait counter expires.
   always_comb begin
      state_nxt      = state;
      mem_state      = 1'b0;
      mem_last       = (wait_cnt == CW'(MEM_WAIT));
      taken          = 1'b0;
      bus.pc_write   = 1'b0;
      bus.adr_src    = 1'b0;
      bus.mem_write  = 1'b0;
      bus.ir_write   = 1'b0;
      bus.reg_write  = 1'b0;
      bus.result_src = 2'b00;
      bus.alu_src_a  = 2'b00;
      bus.alu_src_b  = 2'b00;
      bus.alu_op     = 2'b00;
      bus.imm_src    = 3'b000;
      bus.instr_done = 1'b0;
      bus.illegal_op = 1'b0;

      case (bus.op)
         OP_STORE: bus.imm_src = 3'b001;
         OP_B:     bus.imm_src = 3'b010;
         OP_JAL:   bus.imm_src = 3'b011;
         OP_LUI:   bus.imm_src = 3'b100;
         default:  bus.imm_src = 3'b000;
      endcase

      case (bus.f3)
         3'b000:  taken = bus.zero;
         3'b001:  taken = !bus.zero;
         3'b100:  taken = bus.neg;
         3'b101:  taken = !bus.neg;
         default: taken = 1'b0;
      endcase

      case (state)
         S_FETCH: begin
            mem_state      = 1'b1;
            bus.alu_src_b  = 2'b10;
            bus.result_src = 2'b10;
            if (mem_last) begin
               bus.ir_write = 1'b1;
               bus.pc_write = 1'b1;
               state_nxt    = S_DECODE;
            end
         end
         S_DECODE: begin
            bus.alu_src_a = 2'b01;
            bus.alu_src_b = 2'b01;
            case (bus.op)
               OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
               OP_R:              state_nxt = S_EXECR;
               OP_I:              state_nxt = S_EXECI;
               OP_B:              state_nxt = S_BRANCH;
               OP_JAL:            state_nxt = S_JAL;
               OP_JALR:           state_nxt = S_JALR1;
               OP_LUI:            state_nxt = S_LUI;
               default: begin
                  bus.illegal_op = 1'b1;
                  state_nxt      = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            bus.alu_src_a = 2'b10;
            bus.alu_src_b = 2'b01;
            state_nxt     = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            mem_state   = 1'b1;
            bus.adr_src = 1'b1;
            if (mem_last) state_nxt = S_MEMWB;
         end
         S_MEMWB: begin
            bus.result_src = 2'b01;
            bus.reg_write  = 1'b1;
            bus.instr_done = 1'b1;
            state_nxt      = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_state   = 1'b1;
            bus.adr_src = 1'b1;
            if (mem_last) begin
               bus.mem_write  = 1'b1;
               bus.instr_done = 1'b1;
               state_nxt      = S_FETCH;
            end
         end
         S_EXECR: begin
            bus.alu_src_a = 2'b10;
            bus.alu_op    = 2'b10;
            state_nxt     = S_ALUWB;
         end
         S_EXECI: begin
            bus.alu_src_a = 2'b10;
            bus.alu_src_b = 2'b01;
            bus.alu_op    = 2'b10;
            state_nxt     = S_ALUWB;
         end
         S_LUI: begin
            bus.alu_src_a = 2'b11;
            bus.alu_src_b = 2'b01;
            state_nxt     = S_ALUWB;
         end
         S_ALUWB: begin
            bus.reg_write  = 1'b1;
            bus.instr_done = 1'b1;
            state_nxt      = S_FETCH;
         end
         S_BRANCH: begin
            bus.alu_src_a  = 2'b10;
            bus.alu_op     = 2'b01;
            bus.instr_done = 1'b1;
            bus.pc_write   = taken;
            state_nxt      = S_FETCH;
         end
         S_JAL, S_JALR2: begin
            bus.alu_src_a = 2'b01;
            bus.alu_src_b = 2'b10;
            bus.pc_write  = 1'b1;
            state_nxt     = S_ALUWB;
         end
         S_JALR1: begin
            bus.alu_src_a = 2'b10;
            bus.alu_src_b = 2'b01;
            state_nxt     = S_JALR2;
         end
         default: state_nxt = S_FETCH;
      endcase

      wait_nxt = (mem_state && !mem_last) ? wait_cnt + CW'(1) : '0;

      // Reset silences the datapath in the same cycle it is seen.
      if (rst) begin
         bus.pc_write   = 1'b0;
         bus.adr_src    = 1'b0;
         bus.mem_write  = 1'b0;
         bus.ir_write   = 1'b0;
         bus.reg_write  = 1'b0;
         bus.result_src = 2'b00;
         bus.alu_src_a  = 2'b00;
         bus.alu_src_b  = 2'b00;
         bus.alu_op     = 2'b00;
         bus.imm_src    = 3'b000;
         bus.instr_done = 1'b0;
         bus.illegal_op = 1'b0;
      end
   end
endmodule
